// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - Multi-cycle RV32 ALU issue sequencer (optional SLT_ALIAS_EN: funct3=010 aliases to sltu)
module alu_issue_ctrl #(
    parameter logic [3:0] ILLEGAL_CTRL = 4'hF,
    parameter bit         WB_X0        = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [3:0]  alu_ctrl,
    output logic        alu_b_imm,
    output logic [31:0] imm,
    input  logic [31:0] alu_result,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic        illegal,
    output logic        busy
);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] instr_q;

    logic [31:0] instr_q_next;
    logic        instr_ready_next;
    logic [4:0]  rs1_addr_next;
    logic [4:0]  rs2_addr_next;
    logic [3:0]  alu_ctrl_next;
    logic        alu_b_imm_next;
    logic [31:0] imm_next;
    logic        rd_we_next;
    logic [4:0]  rd_addr_next;
    logic [31:0] rd_wdata_next;
    logic        illegal_next;
    logic        busy_next;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        f3_legal;
    logic [3:0]  f3_ctrl;
    logic        dec_legal;
    logic [3:0]  dec_ctrl;
    logic        dec_b_imm;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

    // funct3 mapping shared by the R-type (funct7=0) and I-type groups.
    always_comb begin
        f3_legal = 1'b1;
        f3_ctrl  = 4'd0;
        case (funct3)
            3'b000: f3_ctrl = 4'd0;
            3'b111: f3_ctrl = 4'd2;
            3'b110: f3_ctrl = 4'd3;
            3'b100: f3_ctrl = 4'd4;
            3'b011: f3_ctrl = 4'd5;
`ifdef SLT_ALIAS_EN
            3'b010: f3_ctrl = 4'd5;
`endif
            default: f3_legal = 1'b0;
        endcase
    end

    always_comb begin
        dec_legal = 1'b0;
        dec_ctrl  = ILLEGAL_CTRL;
        dec_b_imm = 1'b0;
        if (opcode == OP_R) begin
            if (funct7 == 7'b0000000 && f3_legal) begin
                dec_legal = 1'b1;
                dec_ctrl  = f3_ctrl;
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                dec_legal = 1'b1;
                dec_ctrl  = 4'd1;
            end
        end else if (opcode == OP_I && f3_legal) begin
            dec_legal = 1'b1;
            dec_ctrl  = f3_ctrl;
            dec_b_imm = 1'b1;
        end
    end

    // Next-state and next-output logic; every output is a flop fed from here.
    always_comb begin
        state_next       = state;
        instr_q_next     = instr_q;
        instr_ready_next = 1'b0;
        rs1_addr_next    = rs1_addr;
        rs2_addr_next    = rs2_addr;
        alu_ctrl_next    = alu_ctrl;
        alu_b_imm_next   = alu_b_imm;
        imm_next         = imm;
        rd_we_next       = 1'b0;
        rd_addr_next     = rd_addr;
        rd_wdata_next    = rd_wdata;
        illegal_next     = 1'b0;
        case (state)
            IDLE: begin
                instr_ready_next = 1'b1;
                if (instr_valid && instr_ready) begin
                    state_next       = DECODE;
                    instr_ready_next = 1'b0;
                    instr_q_next     = instr;
                    rs1_addr_next    = instr[19:15];
                    rs2_addr_next    = instr[24:20];
                end
            end
            DECODE: begin
                rs1_addr_next  = instr_q[19:15];
                rs2_addr_next  = instr_q[24:20];
                imm_next       = {{20{instr_q[31]}}, instr_q[31:20]};
                alu_ctrl_next  = dec_ctrl;
                alu_b_imm_next = dec_b_imm;
                if (dec_legal) begin
                    state_next = EXEC;
                end else begin
                    state_next       = IDLE;
                    illegal_next     = 1'b1;
                    instr_ready_next = 1'b1;
                end
            end
            EXEC: begin
                state_next    = WB;
                rd_wdata_next = alu_result;
                rd_addr_next  = instr_q[11:7];
                rd_we_next    = WB_X0 || (instr_q[11:7] != 5'd0);
            end
            WB: begin
                state_next       = IDLE;
                instr_ready_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q     <= 32'd0;
            instr_ready <= 1'b0;
            rs1_addr    <= 5'd0;
            rs2_addr    <= 5'd0;
            alu_ctrl    <= 4'd0;
            alu_b_imm   <= 1'b0;
            imm         <= 32'd0;
            rd_we       <= 1'b0;
            rd_addr     <= 5'd0;
            rd_wdata    <= 32'd0;
            illegal     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            instr_q     <= instr_q_next;
            instr_ready <= instr_ready_next;
            rs1_addr    <= rs1_addr_next;
            rs2_addr    <= rs2_addr_next;
            alu_ctrl    <= alu_ctrl_next;
            alu_b_imm   <= alu_b_imm_next;
            imm         <= imm_next;
            rd_we       <= rd_we_next;
            rd_addr     <= rd_addr_next;
            rd_wdata    <= rd_wdata_next;
            illegal     <= illegal_next;
            busy        <= busy_next;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - Directed vector bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] alu_result;

    logic        instr_ready, alu_b_imm, rd_we, illegal, busy;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [3:0]  alu_ctrl;
    logic [31:0] imm, rd_wdata;

    logic        instr_ready_1, alu_b_imm_1, rd_we_1, illegal_1, busy_1;
    logic [4:0]  rs1_addr_1, rs2_addr_1, rd_addr_1;
    logic [3:0]  alu_ctrl_1;
    logic [31:0] imm_1, rd_wdata_1;

    int checks   = 0;
    int failures = 0;

    alu_issue_ctrl #(.ILLEGAL_CTRL(4'hF), .WB_X0(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .alu_ctrl(alu_ctrl),
        .alu_b_imm(alu_b_imm), .imm(imm), .alu_result(alu_result), .rd_we(rd_we),
        .rd_addr(rd_addr), .rd_wdata(rd_wdata), .illegal(illegal), .busy(busy)
    );

    alu_issue_ctrl #(.ILLEGAL_CTRL(4'hF), .WB_X0(1'b1)) dut_x0 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready_1),
        .instr(instr), .rs1_addr(rs1_addr_1), .rs2_addr(rs2_addr_1), .alu_ctrl(alu_ctrl_1),
        .alu_b_imm(alu_b_imm_1), .imm(imm_1), .alu_result(alu_result), .rd_we(rd_we_1),
        .rd_addr(rd_addr_1), .rd_wdata(rd_wdata_1), .illegal(illegal_1), .busy(busy_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] res;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
        logic        bimm;
        logic [31:0] imm;
        logic        ill;
        logic        we0;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        wait_ready();
        instr_valid = 1'b1;
        instr       = v.instr;
        @(negedge clk);
        instr_valid = 1'b0;
        alu_result  = v.res;
        chk({tag, "_t1_ready"}, {31'd0, instr_ready}, 32'd0);
        chk({tag, "_t1_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_rs1"}, {27'd0, rs1_addr}, {27'd0, v.rs1});
        chk({tag, "_rs2"}, {27'd0, rs2_addr}, {27'd0, v.rs2});
        @(negedge clk);
        chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, v.ill});
        chk({tag, "_ctrl"}, {28'd0, alu_ctrl}, {28'd0, v.ctrl});
        chk({tag, "_t2_we"}, {31'd0, rd_we}, 32'd0);
        chk({tag, "_t2_ready"}, {31'd0, instr_ready}, {31'd0, v.ill});
        if (v.ill) begin
            @(negedge clk);
            chk({tag, "_ill_once"}, {31'd0, illegal}, 32'd0);
            chk({tag, "_ill_no_we"}, {31'd0, rd_we}, 32'd0);
            chk({tag, "_ill_no_we_x0"}, {31'd0, rd_we_1}, 32'd0);
        end else begin
            chk({tag, "_bimm"}, {31'd0, alu_b_imm}, {31'd0, v.bimm});
            chk({tag, "_imm"}, imm, v.imm);
            @(negedge clk);
            chk({tag, "_we"}, {31'd0, rd_we}, {31'd0, v.we0});
            chk({tag, "_we_x0"}, {31'd0, rd_we_1}, 32'd1);
            chk({tag, "_rd"}, {27'd0, rd_addr}, {27'd0, v.rd});
            chk({tag, "_rd_x0"}, {27'd0, rd_addr_1}, {27'd0, v.rd});
            chk({tag, "_wdata"}, rd_wdata, v.res);
            chk({tag, "_t3_ready"}, {31'd0, instr_ready}, 32'd0);
            @(negedge clk);
            chk({tag, "_t4_ready"}, {31'd0, instr_ready}, 32'd1);
            chk({tag, "_t4_we"}, {31'd0, rd_we}, 32'd0);
            chk({tag, "_t4_busy"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int first_acc;
        int second_acc;

        //          instr          result        rs1    rs2    rd     ctrl   bimm  imm           ill   we0
        vecs[0] = '{32'h002081B3, 32'h00000007, 5'd1,  5'd2,  5'd3,  4'd0, 1'b0, 32'h00000002, 1'b0, 1'b1};
        vecs[1] = '{32'hFFF00293, 32'hFFFFFFFF, 5'd0,  5'd31, 5'd5,  4'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1};
        vecs[2] = '{32'h40208233, 32'h12345678, 5'd1,  5'd2,  5'd4,  4'd1, 1'b0, 32'h00000402, 1'b0, 1'b1};
        vecs[3] = '{32'h0050B013, 32'h00000001, 5'd1,  5'd5,  5'd0,  4'd5, 1'b1, 32'h00000005, 1'b0, 1'b0};
        vecs[4] = '{32'h0083F333, 32'hA5A5A5A5, 5'd7,  5'd8,  5'd6,  4'd2, 1'b0, 32'h00000008, 1'b0, 1'b1};
        vecs[5] = '{32'h00B564B3, 32'h0F0F0F0F, 5'd10, 5'd11, 5'd9,  4'd3, 1'b0, 32'h0000000B, 1'b0, 1'b1};
        vecs[6] = '{32'h7FF6C613, 32'hDEADBEEF, 5'd13, 5'd31, 5'd12, 4'd4, 1'b1, 32'h000007FF, 1'b0, 1'b1};
        vecs[7] = '{32'h0000007F, 32'h00000000, 5'd0,  5'd0,  5'd0,  4'hF, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[8] = '{32'h40207233, 32'h00000000, 5'd0,  5'd2,  5'd4,  4'hF, 1'b0, 32'h00000402, 1'b1, 1'b0};
`ifdef SLT_ALIAS_EN
        vecs[9] = '{32'h003120B3, 32'h00000001, 5'd2,  5'd3,  5'd1,  4'd5, 1'b0, 32'h00000003, 1'b0, 1'b1};
`else
        vecs[9] = '{32'h003120B3, 32'h00000001, 5'd2,  5'd3,  5'd1,  4'hF, 1'b0, 32'h00000003, 1'b1, 1'b0};
`endif

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'd0;
        alu_result  = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, instr_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_we", {31'd0, rd_we}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        // Valid held high across two instructions: second accept lands 4 cycles later.
        wait_ready();
        first_acc   = -1;
        second_acc  = -1;
        instr       = 32'h002081B3;
        alu_result  = 32'h00000007;
        instr_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk("no_ready_while_busy", {31'd0, instr_ready && busy}, 32'd0);
            if (instr_valid && instr_ready) begin
                if (first_acc < 0) first_acc = k;
                else if (second_acc < 0) second_acc = k;
            end
            @(negedge clk);
            if (second_acc >= 0) instr_valid = 1'b0;
        end
        instr_valid = 1'b0;
        chk("b2b_first", first_acc, 32'd0);
        chk("b2b_second", second_acc, 32'd4);

        // Reset pulled during WB aborts the write asynchronously.
        wait_ready();
        instr_valid = 1'b1;
        instr       = 32'h002081B3;
        @(negedge clk);
        instr_valid = 1'b0;
        alu_result  = 32'h00000055;
        @(negedge clk);
        @(negedge clk);
        chk("wb_we_before_rst", {31'd0, rd_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", {31'd0, rd_we}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ready", {31'd0, instr_ready}, 32'd0);
        chk("arst_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("arst_imm", imm, 32'd0);
        chk("arst_rd_addr", {27'd0, rd_addr}, 32'd0);
        chk("arst_wdata", rd_wdata, 32'd0);
        chk("arst_rs1", {27'd0, rs1_addr}, 32'd0);
        chk("arst_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        chk("arst_hold_we", {31'd0, rd_we}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerun_ready", {31'd0, instr_ready}, 32'd1);
        chk("rerun_busy", {31'd0, busy}, 32'd0);
        chk("rerun_no_we", {31'd0, rd_we}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
